// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5) with a single-stage output register.
// `define CONV_ENC_TAIL_EN to terminate each frame with two zero tail symbols.
module conv_encoder_k3 #(
  parameter logic [2:0] G0     = 3'b111,
  parameter logic [2:0] G1     = 3'b101,
  parameter int         FCNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_bit,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  output logic [1:0]        o_sym,
  output logic              o_last,
  input  logic              i_ready,
  output logic [FCNT_W-1:0] o_frame_cnt
);

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic {RUN, TAIL} state_t;
  state_t state_q, state_d;
  logic   tail_cnt_q, tail_cnt_d;
`endif

  logic              valid_q, valid_d;
  logic [1:0]        sym_q, sym_d;
  logic              last_q, last_d;
  logic [1:0]        s_q, s_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic       slot_free, in_tail, accept, load, enc_u;
  logic [2:0] v;
  logic [1:0] sym;

  always_comb begin
    slot_free = !valid_q || i_ready;
    in_tail   = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    in_tail   = (state_q == TAIL);
`endif
    o_ready = !in_tail && slot_free && !i_rst;
    accept  = i_valid && o_ready;
    load    = accept || (in_tail && slot_free);
    enc_u   = in_tail ? 1'b0 : i_bit;
    v       = {enc_u, s_q};
    sym     = {^(v & G0), ^(v & G1)};

    valid_d = valid_q;
    sym_d   = sym_q;
    last_d  = last_q;
    s_d     = s_q;
    fcnt_d  = fcnt_q;
    if (valid_q && i_ready && last_q)
      fcnt_d = fcnt_q + 1'b1;

    if (load) begin
      valid_d = 1'b1;
      sym_d   = sym;
      last_d  = 1'b0;
      s_d     = {enc_u, s_q[1]};
    end else if (i_ready) begin
      valid_d = 1'b0;
    end

`ifdef CONV_ENC_TAIL_EN
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    case (state_q)
      RUN: begin
        if (accept && i_last) begin
          state_d    = TAIL;
          tail_cnt_d = 1'b0;
        end
      end
      TAIL: begin
        if (slot_free) begin
          tail_cnt_d = tail_cnt_q + 1'b1;
          // Second tail symbol closes the frame; s is 00 again by construction.
          if (tail_cnt_q) begin
            last_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
`else
    // Without tail bits, the last information bit closes the frame and clears s.
    if (accept && i_last) begin
      last_d = 1'b1;
      s_d    = 2'b00;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      sym_q   <= 2'b00;
      last_q  <= 1'b0;
      s_q     <= 2'b00;
      fcnt_q  <= '0;
`ifdef CONV_ENC_TAIL_EN
      state_q    <= RUN;
      tail_cnt_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
      s_q     <= s_d;
      fcnt_q  <= fcnt_d;
`ifdef CONV_ENC_TAIL_EN
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
`endif
    end
  end

  assign o_valid     = valid_q;
  assign o_sym       = sym_q;
  assign o_last      = last_q;
  assign o_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed bench for conv_encoder_k3; expected symbol streams are hand-computed for G0=7, G1=5.
module tb_conv_encoder_k3;
  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_bit, i_last, i_ready;
  logic       o_ready, o_valid, o_last;
  logic [1:0] o_sym;
  logic [7:0] o_frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [2:0] q[$];   // {o_last, o_sym} per output handshake
  int         cq[$];  // cycle of each handshake

  conv_encoder_k3 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_bit(i_bit), .i_last(i_last),
    .o_ready(o_ready), .o_valid(o_valid), .o_sym(o_sym), .o_last(o_last),
    .i_ready(i_ready), .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      q.push_back({o_last, o_sym});
      cq.push_back(cyc);
      $display("sym cyc=%0d sym=%b last=%b fcnt=%0d", cyc, o_sym, o_last, o_frame_cnt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Offer one bit and hold it until the encoder takes it.
  task automatic send_bit(input logic b, input logic l);
    logic rdy;
    logic ok;
    ok = 1'b0;
    i_valid = 1'b1; i_bit = b; i_last = l;
    for (int t = 0; t < 50; t++) begin
      #1;
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    i_valid = 1'b0; i_bit = 1'b0; i_last = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_seq(input string tag, input logic [2:0] exp[8], input int n);
    int m;
    chk({tag, "_len"}, q.size(), n);
    m = (q.size() < n) ? q.size() : n;
    for (int k = 0; k < m; k++)
      chk($sformatf("%s_%0d", tag, k), {29'd0, q[k]}, {29'd0, exp[k]});
  endtask

  logic [2:0] exp[8];
  int n_exp;
  int nlast;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    step(2);
    chk("rst_valid", o_valid, 0);
    chk("rst_sym", o_sym, 0);
    chk("rst_last", o_last, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_ready", o_ready, 0);
    i_rst = 1'b0;
    #1;
    chk("ready_after_rst", o_ready, 1);
    q.delete(); cq.delete();

    // Frame 1,0,1,1 with free-flowing output.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    step(5);
`ifdef CONV_ENC_TAIL_EN
    exp = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111, 3'b000, 3'b000}; n_exp = 6;
`else
    exp = '{3'b011, 3'b010, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000}; n_exp = 4;
`endif
    chk_seq("frame1011", exp, n_exp);
    if (cq.size() == n_exp) chk("frame1011_consecutive", cq[n_exp-1] - cq[0], n_exp - 1);
    chk("fcnt_1", o_frame_cnt, 1);
    q.delete(); cq.delete();

    // Two back-to-back single-bit frames.
    send_bit(1'b1, 1'b1);
`ifdef CONV_ENC_TAIL_EN
    chk("tail_ready0_a", o_ready, 0);
    step(1);
    chk("tail_ready0_b", o_ready, 0);
`endif
    send_bit(1'b1, 1'b1);
    step(5);
`ifdef CONV_ENC_TAIL_EN
    exp = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b111, 3'b000, 3'b000}; n_exp = 6;
`else
    exp = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}; n_exp = 2;
`endif
    chk_seq("single_x2", exp, n_exp);
    chk("fcnt_3", o_frame_cnt, 3);
    q.delete(); cq.delete();

    // Backpressure after the first symbol.
    send_bit(1'b1, 1'b0);
    i_ready = 1'b0; i_valid = 1'b1; i_bit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_valid", o_valid, 1);
      chk("bp_sym", o_sym, 2'b11);
      chk("bp_ready", o_ready, 0);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    step(5);
`ifdef CONV_ENC_TAIL_EN
    exp = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111, 3'b000, 3'b000}; n_exp = 6;
`else
    exp = '{3'b011, 3'b010, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000}; n_exp = 4;
`endif
    chk_seq("backpressure", exp, n_exp);
    chk("fcnt_4", o_frame_cnt, 4);
    q.delete(); cq.delete();

    // Reset right after the last information bit is taken.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_fcnt", o_frame_cnt, 0);
    step(4);
    nlast = 0;
    foreach (q[k]) if (q[k][2]) nlast++;
    chk("midrst_no_last", nlast, 0);
    q.delete(); cq.delete();
    send_bit(1'b1, 1'b1);
    step(5);
    chk("postrst_first_sym", (q.size() > 0) ? {29'd0, q[0]} : 32'hDEAD,
`ifdef CONV_ENC_TAIL_EN
        32'h3);
`else
        32'h7);
`endif
    chk("postrst_fcnt", o_frame_cnt, 1);

    // Counter wrap: 255 more single-bit frames.
    for (int f = 0; f < 254; f++) send_bit(1'b1, 1'b1);
    step(5);
    chk("fcnt_255", o_frame_cnt, 255);
    send_bit(1'b1, 1'b1);
    step(5);
    chk("fcnt_wrap", o_frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder.
- Transmit-side counterpart of the Viterbi decoder. It produces the 2-bit code symbols that the branch metric unit scores: symbol 00/01/10/11 maps to BM_0/BM_1/BM_2/BM_3.
- Accepts one information bit per handshake and emits one registered 2-bit symbol per handshake.
- Terminates each frame with K-1 = 2 zero tail bits, so the decoder traceback starts from state 00.

Parameters:
- G0, 3'b111, generator for symbol bit [1] (octal 7); bit [2] = current input u, bit [1] = s[1], bit [0] = s[0].
- G1, 3'b101, generator for symbol bit [0] (octal 5); same bit mapping as G0.
- FCNT_W, 8, width of the completed-frame counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input bit valid.
- i_bit  in  1  information bit u.
- i_last  in  1  marks the final information bit of a frame.
- o_ready  out  1  encoder can accept an input bit this cycle.
- o_valid  out  1  o_sym/o_last valid.
- o_sym  out  2  code symbol {c0, c1}.
- o_last  out  1  final symbol of the frame.
- i_ready  in  1  downstream accepts the symbol.
- o_frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W.

Behaviour:
- Reset (synchronous, i_rst=1 at the clock edge):
  - o_valid=0, o_sym=2'b00, o_last=0, o_frame_cnt=0.
  - Shift register s=2'b00, tail_cnt=0, FSM=RUN.
  - o_ready is forced 0 while i_rst=1.
  - Reset mid-frame or mid-tail discards the held symbol and any pending tail, with no o_last.
- Encoding:
  - v = {u, s[1], s[0]}; c0 = ^(v & G0), c1 = ^(v & G1); o_sym = {c0, c1}.
  - After each encoded bit, s <= {u, s[1]}.
- Output register: single stage.
  - slot_free = !o_valid || i_ready.
  - o_ready = (FSM==RUN) && slot_free && !i_rst (combinational).
  - Input accept = i_valid && o_ready.
  - On accept, the symbol appears on o_valid/o_sym the next cycle (latency 1).
  - Throughput is 1 symbol/cycle when i_ready stays high.
  - o_valid is cleared when i_ready=1 and no new symbol loads the same cycle.
  - Simultaneous drain and load: the new symbol replaces the old one, with no bubble.
  - While o_valid=1 and i_ready=0, o_sym and o_last hold stable.
- FSM RUN:
  - Accept with i_last=0: encode, stay in RUN.
  - Accept with i_last=1: encode with o_last=0, go to TAIL with tail_cnt=0.
  - i_valid while o_ready=0 is ignored; the source must hold it.
- FSM TAIL:
  - o_ready=0.
  - Each cycle with slot_free, encode u=0 and increment tail_cnt.
  - The second tail symbol carries o_last=1. After it, s=00 (guaranteed by construction) and FSM returns to RUN.
  - A new frame's first bit can be accepted the cycle after the second tail symbol is loaded, subject to slot_free.
- Frame counter: o_frame_cnt increments on the handshake (o_valid && i_ready) of a symbol with o_last=1. It wraps from all-ones to 0.
- Empty frames do not exist: every frame contains at least 1 information bit.
- i_last is sampled only on an accepted bit.

Optional Feature:
- Macro: CONV_ENC_TAIL_EN.
- Defined (default build): frame termination with 2 zero tail symbols, as described above.
- Undefined:
  - No TAIL state.
  - The symbol of the bit accepted with i_last=1 carries o_last=1.
  - s is cleared to 2'b00 on that accept, so the next frame starts from state 00.
  - o_ready depends only on slot_free and i_rst.

Test Plan:
- Frame bits 1,0,1,1 (last on the 4th), i_ready=1, tail enabled -> o_sym sequence 11,10,00,01,01,11 on consecutive cycles; o_last only on the final 11; o_frame_cnt 0->1.
- Same frame with CONV_ENC_TAIL_EN undefined -> 11,10,00,01 with o_last on 01; the next frame bit 1 yields 11 (state cleared).
- Single-bit frame u=1 last -> 11,10,11 (last); o_ready=0 during the 2 tail cycles; a back-to-back second identical frame repeats 11,10,11.
- Backpressure: stream 1,0,1,1, i_ready=0 for 3 cycles after the first symbol -> o_sym holds 11 with o_valid=1; o_ready=0 throughout; the complete sequence is then unchanged with no loss or duplication.
- Reset asserted during TAIL (after the 01 from bit 4) -> next cycle o_valid=0, o_last never seen, o_frame_cnt=0; the new frame bit 1 yields 11.
- Counter wrap: 256 single-bit frames -> o_frame_cnt returns to 0 after the 256th o_last handshake.
